uart_recv: RTL

UART receiver, the receive-side counterpart of `uart_send`: 8N1 framing, LSB first, same `CLK_FREQ`/`UART_BPS` parameterisation. It synchronises the asynchronous `uart_rxd` line, detects the start bit, samples each bit at mid-period, and presents the byte on `uart_data` with a one-cycle `uart_done` strobe. It sits between the board RX pin and the byte consumer (command parser / FIFO) and is the loopback partner of `uart_send` in test.

---
 rtl/uart_recv.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_recv.sv
// UART receiver: 8N1 LSB-first with a mid-bit sampler and registered done/error strobes.
// Define UART_RECV_PARITY_EN to receive 8E1 frames with an even-parity check.
module uart_recv #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       uart_done,
  output logic       frame_err,
  output logic       uart_rx_busy
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CW = $clog2(BPS_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] MID = CW'(BPS_CNT / 2);

`ifdef UART_RECV_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state;
  logic          rxd_s0;
  logic          rxd_s1;
  logic          rxd_s2;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_shift;
  logic          start_trig;
  logic          at_mid;
  logic          at_last;
  logic          stop_ok;
`ifdef UART_RECV_PARITY_EN
  logic          par_bit;
`endif

  // Flops reset high so an idle line never looks like a falling edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rxd_s0 <= 1'b1;
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
    end else begin
      rxd_s0 <= uart_rxd;
      rxd_s1 <= rxd_s0;
      rxd_s2 <= rxd_s1;
    end
  end

  assign start_trig = rxd_s2 & ~rxd_s1;
  assign at_mid = (clk_cnt == MID);
  assign at_last = (clk_cnt == LAST);

`ifdef UART_RECV_PARITY_EN
  assign stop_ok = rxd_s1 & (par_bit == ^rx_shift);
`else
  assign stop_ok = rxd_s1;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= IDLE;
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      uart_data    <= '0;
      uart_done    <= 1'b0;
      frame_err    <= 1'b0;
      uart_rx_busy <= 1'b0;
`ifdef UART_RECV_PARITY_EN
      par_bit      <= 1'b0;
`endif
    end else begin
      uart_done <= 1'b0;
      frame_err <= 1'b0;
      if (state != IDLE)
        clk_cnt <= at_last ? '0 : clk_cnt + CW'(1);
      unique case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (start_trig) begin
            state        <= START;
            uart_rx_busy <= 1'b1;
          end
        end
        START: begin
          if (at_mid && rxd_s1) begin
            state        <= IDLE;
            clk_cnt      <= '0;
            uart_rx_busy <= 1'b0;
          end else if (at_last) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (at_mid)
            rx_shift[bit_cnt] <= rxd_s1;
          if (at_last) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
`ifdef UART_RECV_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
          end
        end
`ifdef UART_RECV_PARITY_EN
        PARITY: begin
          if (at_mid)
            par_bit <= rxd_s1;
          if (at_last)
            state <= STOP;
        end
`endif
        // Leave at the stop-bit centre so back-to-back frames are caught.
        STOP: begin
          if (at_mid) begin
            state        <= IDLE;
            clk_cnt      <= '0;
            uart_rx_busy <= 1'b0;
            if (stop_ok) begin
              uart_data <= rx_shift;
              uart_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: begin
          state        <= IDLE;
          clk_cnt      <= '0;
          uart_rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
